divisor_arbiter: RTL and testbench

- Shares one divisor datapath (start/numerator/denominator in; quotient/remainder/done out) between N requesters.
- Round-robin arbitration; one division in flight at a time.
- Returns each result tagged to its requester.
- Handles divide-by-zero locally without starting the divisor.
- A watchdog converts a stuck divisor into an error response.
- Sits between client blocks and the divisor_top instance, driving its stimulus-side signals.

---
 rtl/divisor_pkg.sv | 22 ++
 rtl/divisor_arbiter_if.sv | 41 ++++
 rtl/divisor_arbiter_rr_picker.sv | 35 +++
 rtl/divisor_arbiter.sv | 156 +++++++++++++++
 tb/tb_divisor_arbiter.sv | 320 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/divisor_pkg.sv
// Shared types and constants for the divisor arbiter slice.
package divisor_pkg;

    // Default operand/result width; must agree with the divisor instance.
    localparam int DIV_SIZE     = 32;
    // Widest operand the divide-by-zero helper can cover.
    localparam int DIV_MAX_SIZE = 64;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } arb_state_t;

    // Quotient reported for a divide-by-zero request: all ones.
    // Callers keep the low SIZE bits.
    function automatic logic [DIV_MAX_SIZE-1:0] dz_quotient();
        return '1;
    endfunction

endpackage

// File: rtl/divisor_arbiter_if.sv
// Bundle of the requester-side and divisor-side signals of the arbiter.
interface divisor_arbiter_if
    import divisor_pkg::*;
#(
    parameter int SIZE  = DIV_SIZE,
    parameter int N_REQ = 4
);
    // requester side
    logic [N_REQ-1:0]      req;
    logic [N_REQ*SIZE-1:0] num_in;
    logic [N_REQ*SIZE-1:0] den_in;
    logic [N_REQ-1:0]      gnt;
    logic [N_REQ-1:0]      resp_valid;
    logic [SIZE-1:0]       resp_coc;
    logic [SIZE-1:0]       resp_res;
    logic                  resp_dz;
    logic                  resp_to;
    logic                  busy;
    // divisor side
    logic                  div_start;
    logic [SIZE-1:0]       div_num;
    logic [SIZE-1:0]       div_den;
    logic [SIZE-1:0]       div_coc;
    logic [SIZE-1:0]       div_res;
    logic                  div_done;

    // arbiter view
    modport slave (
        input  req, num_in, den_in, div_coc, div_res, div_done,
        output gnt, resp_valid, resp_coc, resp_res, resp_dz, resp_to, busy,
               div_start, div_num, div_den
    );

    // clients plus divisor view
    modport master (
        output req, num_in, den_in, div_coc, div_res, div_done,
        input  gnt, resp_valid, resp_coc, resp_res, resp_dz, resp_to, busy,
               div_start, div_num, div_den
    );

endinterface

// File: rtl/divisor_arbiter_rr_picker.sv
// Round-robin picker: first set request bit searching upward from ptr+1,
// wrapping around. Purely combinational.
module rr_picker #(
    parameter  int N_REQ = 4,
    localparam int IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] i_req,
    input  logic [IDX_W-1:0] i_ptr,
    output logic [N_REQ-1:0] o_gnt,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_valid
);

    logic             w_found;
    logic [IDX_W-1:0] w_cand;

    assign o_valid = |i_req;

    // Walk the requesters in rotated order and keep the first hit.
    always_comb begin
        o_gnt   = '0;
        o_idx   = '0;
        w_found = 1'b0;
        w_cand  = '0;
        for (int off = 1; off <= N_REQ; off++) begin
            w_cand = IDX_W'((int'(i_ptr) + off) % N_REQ);
            if (!w_found && i_req[w_cand]) begin
                w_found       = 1'b1;
                o_gnt[w_cand] = 1'b1;
                o_idx         = w_cand;
            end
        end
    end

endmodule

// File: rtl/divisor_arbiter.sv
// Shares one divisor between N_REQ requesters: round-robin grant, local
// divide-by-zero handling and a watchdog that turns a stuck divisor into
// an error response.
module divisor_arbiter
    import divisor_pkg::*;
#(
    parameter int SIZE    = DIV_SIZE,
    parameter int N_REQ   = 4,
    parameter int TIMEOUT = 64
) (
    input logic              clk,
    input logic              rst,
    divisor_arbiter_if.slave bus
);

    localparam int IDX_W = $clog2(N_REQ);
    localparam int WD_W  = $clog2(TIMEOUT + 1);
    localparam logic [DIV_MAX_SIZE-1:0] DZ_WIDE = dz_quotient();

    arb_state_t       r_state;
    arb_state_t       w_state_next;
    logic [IDX_W-1:0] r_id;
    logic [IDX_W-1:0] r_ptr;
    logic [SIZE-1:0]  r_num;
    logic [SIZE-1:0]  r_den;
    logic [SIZE-1:0]  r_coc;
    logic [SIZE-1:0]  r_res;
    logic             r_dz;
    logic             r_to;
    logic [WD_W-1:0]  r_wd_cnt;

    logic [SIZE-1:0]  w_num [N_REQ];
    logic [SIZE-1:0]  w_den [N_REQ];
    logic [N_REQ-1:0] w_pick_gnt;
    logic [IDX_W-1:0] w_pick_idx;
    logic             w_pick_valid;
    logic [SIZE-1:0]  w_sel_num;
    logic [SIZE-1:0]  w_sel_den;
    logic [N_REQ-1:0] w_gnt;
    logic [N_REQ-1:0] w_resp_valid;
    logic             w_wd_expired;

    // Unpack per-requester operand slices; decode the response strobe.
    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_req
            assign w_num[gi]        = bus.num_in[gi*SIZE +: SIZE];
            assign w_den[gi]        = bus.den_in[gi*SIZE +: SIZE];
            assign w_resp_valid[gi] = (r_state == RESP) && (r_id == IDX_W'(gi));
        end
    endgenerate

    rr_picker #(.N_REQ(N_REQ)) u_picker (
        .i_req   (bus.req),
        .i_ptr   (r_ptr),
        .o_gnt   (w_pick_gnt),
        .o_idx   (w_pick_idx),
        .o_valid (w_pick_valid)
    );

    assign w_sel_num    = w_num[w_pick_idx];
    assign w_sel_den    = w_den[w_pick_idx];
    assign w_wd_expired = (r_wd_cnt == WD_W'(TIMEOUT - 1));

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and grant decode; a zero denominator skips the divisor.
    always_comb begin
        w_state_next = r_state;
        w_gnt        = '0;
        case (r_state)
            IDLE: begin
                if (w_pick_valid) begin
                    w_gnt        = w_pick_gnt;
                    w_state_next = (w_sel_den == '0) ? RESP : ISSUE;
                end
            end
            ISSUE: w_state_next = WAIT;
            WAIT: begin
                if (bus.div_done || w_wd_expired) begin
                    w_state_next = RESP;
                end
            end
            RESP:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // Operand capture, watchdog, result registers and round-robin pointer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_id     <= '0;
            r_ptr    <= IDX_W'(N_REQ - 1);
            r_num    <= '0;
            r_den    <= '0;
            r_coc    <= '0;
            r_res    <= '0;
            r_dz     <= 1'b0;
            r_to     <= 1'b0;
            r_wd_cnt <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_pick_valid) begin
                        r_id  <= w_pick_idx;
                        r_num <= w_sel_num;
                        r_den <= w_sel_den;
                        if (w_sel_den == '0) begin
                            r_coc <= DZ_WIDE[SIZE-1:0];
                            r_res <= w_sel_num;
                            r_dz  <= 1'b1;
                            r_to  <= 1'b0;
                        end
                    end
                end
                ISSUE: r_wd_cnt <= '0;
                WAIT: begin
                    // A done arriving on the expiry cycle still wins.
                    if (bus.div_done) begin
                        r_coc <= bus.div_coc;
                        r_res <= bus.div_res;
                        r_dz  <= 1'b0;
                        r_to  <= 1'b0;
                    end else if (w_wd_expired) begin
                        r_coc <= '0;
                        r_res <= '0;
                        r_dz  <= 1'b0;
                        r_to  <= 1'b1;
                    end else begin
                        r_wd_cnt <= r_wd_cnt + 1'b1;
                    end
                end
                RESP:    r_ptr <= r_id;
                default: ;
            endcase
        end
    end

    assign bus.gnt        = w_gnt;
    assign bus.resp_valid = w_resp_valid;
    assign bus.resp_coc   = r_coc;
    assign bus.resp_res   = r_res;
    assign bus.resp_dz    = r_dz;
    assign bus.resp_to    = r_to;
    assign bus.busy       = (r_state != IDLE);
    assign bus.div_start  = (r_state == ISSUE);
    assign bus.div_num    = r_num;
    assign bus.div_den    = r_den;

endmodule

// File: tb/tb_divisor_arbiter.sv
// Randomised and directed bench for divisor_arbiter. A behavioural divisor
// answers div_start after a chosen latency; a scoreboard predicts grants
// (round-robin over the driven request levels) and responses (/ and %).
module tb_divisor_arbiter;
    import divisor_pkg::*;

    localparam int SIZE    = 32;
    localparam int N       = 4;
    localparam int TIMEOUT = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;

    divisor_arbiter_if #(.SIZE(SIZE), .N_REQ(N)) u_if ();

    divisor_arbiter #(.SIZE(SIZE), .N_REQ(N), .TIMEOUT(TIMEOUT)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (u_if)
    );

    initial forever #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    // client stimulus
    logic [N-1:0]    req_v;
    logic [N-1:0]    granted;
    logic [SIZE-1:0] num_arr [N];
    logic [SIZE-1:0] den_arr [N];

    // scoreboard for the single transaction in flight
    bit              outstanding;
    int              o_id, o_gcyc, o_due;
    logic [SIZE-1:0] o_num, o_den, o_coc, o_res;
    bit              o_dz, o_to;
    int              m_ptr;
    int              grant_log [$];

    // behavioural divisor
    bit              cont_mode, rand_mode, stub_mode, late_done, start_seen;
    int              force_lat, lat, cd;
    logic [SIZE-1:0] snum, sden;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s @cyc %0d: got 0x%0h, want 0x%0h", tag, cyc, got, exp);
        end
    endtask

    function automatic int rr_pick(input logic [N-1:0] r, input int p);
        for (int k = 1; k <= N; k++) begin
            int j;
            j = (p + k) % N;
            if (((r >> j) & 1) != 0) return j;
        end
        return -1;
    endfunction

    task automatic drive_bus();
        u_if.req = req_v;
        for (int i = 0; i < N; i++) begin
            u_if.num_in[i*SIZE +: SIZE] = num_arr[i];
            u_if.den_in[i*SIZE +: SIZE] = den_arr[i];
        end
    endtask

    task automatic do_reset();
        rst          = 1'b1;
        req_v        = '0;
        cd           = 0;
        start_seen   = 1'b0;
        late_done    = 1'b0;
        u_if.div_done = 1'b0;
        drive_bus();
        #1;
        chk("rst_gnt",        u_if.gnt,        0);
        chk("rst_resp_valid", u_if.resp_valid, 0);
        chk("rst_busy",       u_if.busy,       0);
        chk("rst_div_start",  u_if.div_start,  0);
        chk("rst_div_num",    u_if.div_num,    0);
        chk("rst_div_den",    u_if.div_den,    0);
        chk("rst_resp_coc",   u_if.resp_coc,   0);
        chk("rst_resp_res",   u_if.resp_res,   0);
        chk("rst_resp_dz",    u_if.resp_dz,    0);
        chk("rst_resp_to",    u_if.resp_to,    0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst         = 1'b0;
        outstanding = 1'b0;
        o_due       = 32'h7fff_ffff;
        m_ptr       = N - 1;
        granted     = '0;
        grant_log.delete();
    endtask

    // One clock: observe and check at negedge, then drive just after posedge.
    task automatic step();
        logic [N-1:0] exp_gnt;
        logic [N-1:0] exp_rv;
        int           pick;
        @(negedge clk);
        cyc++;
        exp_gnt = '0;
        pick    = -1;
        granted = '0;
        if (!outstanding && req_v != '0) begin
            pick    = rr_pick(req_v, m_ptr);
            exp_gnt = N'(1) << pick;
        end
        chk("gnt", u_if.gnt, exp_gnt);
        chk("busy", u_if.busy, outstanding);
        chk("div_start", u_if.div_start, (outstanding && !o_dz && cyc == o_gcyc + 1));
        if (outstanding && !o_dz && cyc > o_gcyc && cyc < o_due) begin
            chk("div_num", u_if.div_num, o_num);
            chk("div_den", u_if.div_den, o_den);
        end
        if (u_if.div_start) begin
            start_seen = 1'b1;
            snum       = u_if.div_num;
            sden       = u_if.div_den;
            lat        = (force_lat > 0) ? force_lat : $urandom_range(1, TIMEOUT);
            if (outstanding && !o_dz) begin
                if (stub_mode) begin
                    o_due = cyc + TIMEOUT + 1;
                    o_coc = '0;
                    o_res = '0;
                    o_to  = 1'b1;
                end else begin
                    o_due = cyc + lat + 1;
                end
            end
        end
        exp_rv = (outstanding && cyc == o_due) ? (N'(1) << o_id) : '0;
        chk("resp_valid", u_if.resp_valid, exp_rv);
        if (exp_rv != '0) begin
            chk("resp_coc", u_if.resp_coc, o_coc);
            chk("resp_res", u_if.resp_res, o_res);
            chk("resp_dz",  u_if.resp_dz,  o_dz);
            chk("resp_to",  u_if.resp_to,  o_to);
            $display("resp req%0d num=0x%0h den=0x%0h -> coc=0x%0h res=0x%0h dz=%0d to=%0d @cyc %0d",
                     o_id, o_num, o_den, u_if.resp_coc, u_if.resp_res,
                     u_if.resp_dz, u_if.resp_to, cyc);
            m_ptr       = o_id;
            outstanding = 1'b0;
        end
        if (pick >= 0) begin
            outstanding = 1'b1;
            o_id        = pick;
            o_gcyc      = cyc;
            o_num       = num_arr[pick];
            o_den       = den_arr[pick];
            o_to        = 1'b0;
            if (o_den == '0) begin
                o_coc = '1;
                o_res = o_num;
                o_dz  = 1'b1;
                o_due = cyc + 1;
            end else begin
                o_coc = o_num / o_den;
                o_res = o_num % o_den;
                o_dz  = 1'b0;
                o_due = 32'h7fff_ffff;
            end
            grant_log.push_back(pick);
            granted = exp_gnt;
        end

        @(posedge clk); #1;
        req_v = req_v & ~granted;
        // reassert in the same cycle the response comes back
        if (cont_mode && outstanding && o_due == cyc + 1) req_v = req_v | (N'(1) << o_id);
        if (rand_mode) begin
            for (int i = 0; i < N; i++) begin
                if (req_v[i] == 1'b0 && !(outstanding && o_id == i)) begin
                    if ($urandom_range(0, 3) == 0) begin
                        num_arr[i] = $urandom;
                        if ($urandom_range(0, 7) == 0)      den_arr[i] = '0;
                        else if ($urandom_range(0, 1) == 0) den_arr[i] = $urandom_range(1, 255);
                        else                                den_arr[i] = $urandom;
                        req_v[i] = 1'b1;
                    end
                end else if (req_v[i] && $urandom_range(0, 19) == 0) begin
                    req_v[i] = 1'b0;
                end
            end
        end
        u_if.div_done = 1'b0;
        if (start_seen) begin
            cd         = lat;
            start_seen = 1'b0;
        end
        if (cd > 0) begin
            cd--;
            if (cd == 0 && !stub_mode) begin
                u_if.div_done = 1'b1;
                u_if.div_coc  = snum / sden;
                u_if.div_res  = snum % sden;
            end
        end
        if (late_done) begin
            u_if.div_done = 1'b1;
            u_if.div_coc  = $urandom;
            u_if.div_res  = $urandom;
            late_done     = 1'b0;
        end
        drive_bus();
    endtask

    task automatic run_until_idle(input int max_cyc);
        int n;
        n = 0;
        while ((outstanding || req_v != '0) && n < max_cyc) begin
            step();
            n++;
        end
        chk("drain_bound", (outstanding || req_v != '0), 0);
    endtask

    initial begin
        int n;
        cont_mode = 0; rand_mode = 0; stub_mode = 0; late_done = 0;
        force_lat = 0; lat = 1; cd = 0; start_seen = 0;
        snum = '0; sden = '1; o_dz = 0; o_gcyc = 0; o_id = 0;
        for (int i = 0; i < N; i++) begin
            num_arr[i] = '0;
            den_arr[i] = 32'd1;
        end
        u_if.div_coc = '0;
        u_if.div_res = '0;
        do_reset();

        // single request
        num_arr[0] = 32'd100; den_arr[0] = 32'd7; req_v = 4'b0001;
        drive_bus();
        run_until_idle(50);

        // all four requesting continuously
        do_reset();
        for (int i = 0; i < N; i++) begin
            num_arr[i] = 32'(50 + i);
            den_arr[i] = 32'd5;
        end
        req_v = '1; cont_mode = 1;
        drive_bus();
        n = 0;
        while (grant_log.size() < 5 && n < 200) begin
            step();
            n++;
        end
        cont_mode = 0; req_v = '0;
        drive_bus();
        run_until_idle(50);
        for (int k = 0; k < 5; k++) begin
            chk("rr_order", (k < grant_log.size()) ? grant_log[k] : -1, k % N);
        end

        // divide by zero
        do_reset();
        num_arr[2] = 32'h1234; den_arr[2] = '0; req_v = 4'b0100;
        drive_bus();
        run_until_idle(20);

        // watchdog with a divisor that never answers, then a late done
        do_reset();
        stub_mode = 1;
        num_arr[0] = 32'd77; den_arr[0] = 32'd7; req_v = 4'b0001;
        drive_bus();
        run_until_idle(60);
        late_done = 1;
        repeat (4) step();
        chk("late_busy",    u_if.busy,     0);
        chk("late_hold_to", u_if.resp_to,  1);
        chk("late_hold_coc", u_if.resp_coc, 0);
        chk("late_hold_res", u_if.resp_res, 0);
        stub_mode = 0;

        // reset in the middle of WAIT
        do_reset();
        force_lat = TIMEOUT;
        num_arr[0] = 32'd1000; den_arr[0] = 32'd3; req_v = 4'b0001;
        drive_bus();
        n = 0;
        while (!(outstanding && cyc >= o_gcyc + 3) && n < 20) begin
            step();
            n++;
        end
        chk("midwait_busy", u_if.busy, 1);
        do_reset();
        force_lat = 0;
        num_arr[0] = 32'd9; den_arr[0] = 32'd3; req_v = 4'b0001;
        drive_bus();
        run_until_idle(50);

        // boundary operands
        do_reset();
        num_arr[0] = 32'hFFFF_FFFF; den_arr[0] = 32'd1; req_v = 4'b0001;
        drive_bus();
        run_until_idle(50);
        num_arr[1] = 32'd5; den_arr[1] = 32'd9; req_v = 4'b0010;
        drive_bus();
        run_until_idle(50);

        // randomised traffic
        do_reset();
        rand_mode = 1;
        repeat (800) step();
        rand_mode = 0; req_v = '0;
        drive_bus();
        run_until_idle(100);

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_errors);
        $finish;
    end

endmodule
